// File: rtl/sra_srl_32_iterative_pkg.sv
// Package for the iterative right shifter (sra_srl_32_iterative).
// Holds the FSM state encoding and the default operand / shift-amount widths.
// Optional build macro used by the block: SHIFT_FAST4_EN (4-position steps).
package sra_srl_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sra_srl_32_iterative_if.sv
// Request/result interface of the iterative right shifter.
//   start, a, b, arith : request side, driven by the master (execute stage)
//   ready, busy, done  : status, driven by the shifter
//   s                  : result register, driven by the shifter
//   state_dbg          : current FSM state, exposed for checkers
// Handshake: a request is taken on a rising clock edge where start=1 and
// ready=1; a/b/arith are only sampled on that edge.  done pulses for one cycle
// when s holds the new result; s then keeps that value until the next done.
interface sra_srl_32_iterative_if #(
    parameter int WIDTH   = sra_srl_pkg::WIDTH_DEFAULT,
    parameter int SHAMT_W = sra_srl_pkg::SHAMT_W_DEFAULT
);
    import sra_srl_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   a;
    logic [SHAMT_W-1:0] b;
    logic               arith;
    logic               ready;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   s;
    state_t             state_dbg;

    modport master (
        output start, a, b, arith,
        input  ready, busy, done, s, state_dbg
    );

    modport slave (
        input  start, a, b, arith,
        output ready, busy, done, s, state_dbg
    );

endinterface

// File: rtl/sra_srl_32_iterative_srl_step.sv
// srl_step: combinational single step of the right shifter.
//   data  : word to shift
//   fill  : bit shifted in at the MSB end
//   step4 : (only with SHIFT_FAST4_EN) 1 = shift by 4, 0 = shift by 1
//   out   : shifted word
// The fill bit is prepended to the data as a sign bit so that an arithmetic
// shift of the widened word replicates it into every vacated position.
module srl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
`ifdef SHIFT_FAST4_EN
    input  logic             step4,
`endif
    output logic [WIDTH-1:0] out
);

    logic signed [WIDTH:0] ext;

    assign ext = {fill, data};

`ifdef SHIFT_FAST4_EN
    assign out = step4 ? WIDTH'(ext >>> 4) : WIDTH'(ext >>> 1);
`else
    assign out = WIDTH'(ext >>> 1);
`endif

endmodule

// File: rtl/sra_srl_32_iterative.sv
// sra_srl_32_iterative: multi-cycle logical/arithmetic right shifter.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (aborts any operation in flight)
//   bus : sra_srl_32_iterative_if.slave (start/a/b/arith in,
//         ready/busy/done/s/state_dbg out)
// A request loads the working register, the remaining count and the fill bit,
// then the FSM shifts one position per cycle until the count reaches zero,
// copies the working register into s and pulses done.
// Build option: define SHIFT_FAST4_EN to shift by 4 while count >= 4, which
// shortens latency without changing any result.
module sra_srl_32_iterative
    import sra_srl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    sra_srl_32_iterative_if.slave       bus
);

    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               fill_q,  fill_d;
    logic [WIDTH-1:0]   s_q,     s_d;
    logic               ready_q, ready_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;

    logic [WIDTH-1:0]   step_out;
    logic [SHAMT_W-1:0] step_dec;

`ifdef SHIFT_FAST4_EN
    localparam logic [SHAMT_W-1:0] CNT_FOUR = SHAMT_W'(4);
    logic step4;

    assign step4    = (count_q >= CNT_FOUR);
    assign step_dec = step4 ? CNT_FOUR : CNT_ONE;

    srl_step #(.WIDTH(WIDTH)) u_step (
        .data  (work_q),
        .fill  (fill_q),
        .step4 (step4),
        .out   (step_out)
    );
`else
    assign step_dec = CNT_ONE;

    srl_step #(.WIDTH(WIDTH)) u_step (
        .data  (work_q),
        .fill  (fill_q),
        .out   (step_out)
    );
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        fill_d  = fill_q;
        s_d     = s_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d  = bus.a;
                    count_d = bus.b;
                    // Sign is captured now; later changes to a do not matter.
                    fill_d  = bus.arith & bus.a[WIDTH-1];
                    state_d = SHIFT;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (count_q == CNT_ZERO) begin
                    s_d     = work_q;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    work_d  = step_out;
                    count_d = count_q - step_dec;
                end
            end
            DONE: begin
                // start is ignored here: ready is still low.
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            fill_q  <= 1'b0;
            s_q     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            fill_q  <= fill_d;
            s_q     <= s_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.s         = s_q;
    assign bus.state_dbg = state_q;

endmodule
